// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants for the write-only I2C master
package i2c_pkg;

  // Transfer states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_ADDR     = 3'd2;
  localparam logic [2:0] ST_ADDR_ACK = 3'd3;
  localparam logic [2:0] ST_DATA     = 3'd4;
  localparam logic [2:0] ST_DATA_ACK = 3'd5;
  localparam logic [2:0] ST_STOP     = 3'd6;

  // Quarter phases within one bit period
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Direction bit appended to the address: this master only writes
  localparam logic W_BIT = 1'b0;

  // SCL is low in the first half of a bit and high in the second half
  function automatic logic scl_level(input logic [1:0] phase);
    return phase[1];
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - divider producing one qtick every CLK_DIV clocks
module i2c_quarter_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic qtick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign qtick = (cnt_q == LAST);

  // Count up to CLK_DIV-1 and wrap; restart realigns the quarter grid to accept
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || qtick) begin
      cnt_d = '0;
    end
  end

  // Divider counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_master_tx.sv
// rtl/i2c_master_tx.sv - write-only I2C master: START, address+W, one data byte, STOP
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_i
);

  logic [2:0] state_q,  state_d;
  logic [1:0] phase_q,  phase_d;
  logic [2:0] bcnt_q,   bcnt_d;
  logic [7:0] shift_q,  shift_d;
  logic [7:0] data_q,   data_d;
  logic       nack_q,   nack_d;
  logic       ack_err_q, ack_err_d;
  logic       done_q,   done_d;
  logic       busy_q,   busy_d;
  logic       scl_q,    scl_d;
  logic       sda_oe_q, sda_oe_d;
  logic       qfirst_q, qfirst_d;

  logic accept;
  logic qtick;

  assign accept = (state_q == ST_IDLE) && start;

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_qtick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (accept),
    .qtick   (qtick)
  );

  // Sequencer: accept, ACK sampling and bit/quarter advance.
  // START and STOP each span two bit periods: START leads with one idle bit
  // (bus released, SCL high) before the START sequence, STOP trails its
  // sequence with one bus-free bit before reporting done.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    nack_d    = nack_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    qfirst_d  = (state_q != ST_IDLE) && qtick;

    if (accept) begin
      state_d   = ST_START;
      phase_d   = Q0;
      bcnt_d    = 3'd0;
      shift_d   = {addr, W_BIT};
      data_d    = data_in;
      nack_d    = 1'b0;
      ack_err_d = 1'b0;
      qfirst_d  = 1'b1;
    end else if (state_q != ST_IDLE) begin
      // ACK is taken on the first clock of the SCL-high half of the ACK bit
      if ((state_q == ST_ADDR_ACK || state_q == ST_DATA_ACK) &&
          phase_q == Q2 && qfirst_q) begin
        nack_d = sda_i;
        if (sda_i) begin
          ack_err_d = 1'b1;
        end
      end

      if (qtick) begin
        phase_d = phase_q + 2'd1;
        if (phase_q == Q3) begin
          case (state_q)
            ST_START: begin
              if (bcnt_q == 3'd0) begin
                bcnt_d = 3'd1;
              end else begin
                state_d = ST_ADDR;
                bcnt_d  = 3'd0;
              end
            end
            ST_ADDR, ST_DATA: begin
              shift_d = {shift_q[6:0], 1'b0};
              bcnt_d  = bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) begin
                state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
              end
            end
            ST_ADDR_ACK: begin
              bcnt_d = 3'd0;
              if (nack_q) begin
                state_d = ST_STOP;
              end else begin
                state_d = ST_DATA;
                shift_d = data_q;
              end
            end
            ST_DATA_ACK: begin
              bcnt_d  = 3'd0;
              state_d = ST_STOP;
            end
            ST_STOP: begin
              if (bcnt_q == 3'd0) begin
                bcnt_d = 3'd1;
              end else begin
                state_d = ST_IDLE;
                bcnt_d  = 3'd0;
                done_d  = 1'b1;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Bus levels for the upcoming cycle, decoded from next state so the pad
  // drivers come straight from flops
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_d)
      ST_START: begin
        if (bcnt_d == 3'd1) begin
          scl_d    = (phase_d != Q3);
          sda_oe_d = phase_d[1];
        end
      end
      ST_ADDR, ST_DATA: begin
        scl_d    = scl_level(phase_d);
        sda_oe_d = ~shift_d[7];
      end
      ST_ADDR_ACK, ST_DATA_ACK: begin
        scl_d = scl_level(phase_d);
      end
      ST_STOP: begin
        if (bcnt_d == 3'd0) begin
          scl_d    = scl_level(phase_d);
          sda_oe_d = (phase_d != Q3);
        end
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset releases the bus at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= Q0;
      bcnt_q    <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      nack_q    <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      qfirst_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      nack_q    <= nack_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      qfirst_q  <= qfirst_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign scl     = scl_q;
  assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// tb/tb_i2c_master_tx.sv - self-checking bench for i2c_master_tx with bus monitor and slave model
module tb_i2c_master_tx;

  logic clk;
  logic reset_n;
  logic start;
  logic sel;
  logic [6:0] addr;
  logic [7:0] data_in;

  logic start0, start1;
  logic busy0, done0, err0, scl0, oe0, sda_i0;
  logic busy1, done1, err1, scl1, oe1, sda_i1;
  logic busy_m, done_m, err_m, scl_m, oe_m;

  logic slave_low = 1'b0;
  logic ack_a_cfg = 1'b0;
  logic ack_d_cfg = 1'b0;

  int checks = 0;
  int failures = 0;

  int ev_q[$];
  int rise_cnt = 0;
  int last_rise = -1;
  int bad_period = 0;
  int exp_period = 8;
  int cyc = 0;
  int done_cnt = 0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;
  logic rise_seen = 1'b0;
  logic rise_val = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign sda_i0 = ~(oe0 | slave_low);
  assign sda_i1 = ~(oe1 | slave_low);

  assign busy_m = sel ? busy1 : busy0;
  assign done_m = sel ? done1 : done0;
  assign err_m  = sel ? err1  : err0;
  assign scl_m  = sel ? scl1  : scl0;
  assign oe_m   = sel ? oe1   : oe0;

  i2c_master_tx #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start0), .addr(addr), .data_in(data_in),
    .busy(busy0), .done(done0), .ack_err(err0), .scl(scl0), .sda_oe(oe0), .sda_i(sda_i0)
  );

  i2c_master_tx #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .addr(addr), .data_in(data_in),
    .busy(busy1), .done(done1), .ack_err(err1), .scl(scl1), .sda_oe(oe1), .sda_i(sda_i1)
  );

  // Bus monitor and ACKing slave: decodes S/P and bits from the selected master
  always @(negedge clk) begin
    logic sda_now;
    cyc = cyc + 1;
    sda_now = ~(oe_m | slave_low);
    if (done0 | done1) done_cnt = done_cnt + 1;
    if (prev_scl && scl_m && prev_sda && !sda_now) begin
      ev_q.push_back(2);
      rise_cnt = 0;
      rise_seen = 1'b0;
      last_rise = -1;
      slave_low = 1'b0;
    end else if (prev_scl && scl_m && !prev_sda && sda_now) begin
      ev_q.push_back(3);
      rise_seen = 1'b0;
    end else if (!prev_scl && scl_m) begin
      rise_cnt = rise_cnt + 1;
      if (last_rise >= 0 && (cyc - last_rise) != exp_period) bad_period = bad_period + 1;
      last_rise = cyc;
      rise_seen = 1'b1;
      rise_val = sda_now;
    end else if (prev_scl && !scl_m) begin
      if (rise_seen) ev_q.push_back(rise_val ? 1 : 0);
      rise_seen = 1'b0;
      slave_low = (rise_cnt == 8 && ack_a_cfg) || (rise_cnt == 17 && ack_d_cfg);
    end
    prev_scl = scl_m;
    prev_sda = sda_now;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_xfer(input bit s, input logic [6:0] a, input logic [7:0] d,
                          input bit aa, input bit ad, input bit hold);
    int div, n, gap, exp_lat, mism, dstart;
    int exp_q[$];
    logic [7:0] byte_v;
    logic exp_err;
    div = s ? 1 : 2;
    @(negedge clk);
    sel = s;
    ack_a_cfg = aa;
    ack_d_cfg = ad;
    exp_period = 4 * div;

    // Reference frame from the protocol: S, addr MSB first, W, ACK, [data, ACK], P
    exp_q.push_back(2);
    for (int i = 6; i >= 0; i--) exp_q.push_back(a[i] ? 1 : 0);
    exp_q.push_back(0);
    exp_q.push_back(aa ? 0 : 1);
    if (aa) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(d[i] ? 1 : 0);
      exp_q.push_back(ad ? 0 : 1);
    end
    exp_q.push_back(3);
    exp_lat = (aa ? 22 : 13) * 4 * div + 1;
    exp_err = !aa || !ad;

    @(negedge clk);
    ev_q.delete();
    bad_period = 0;
    dstart = done_cnt;
    addr = a;
    data_in = d;
    start = 1'b1;
    @(negedge clk);
    n = 1;
    gap = 0;
    check("busy_on_accept", busy_m, 1);
    check("ack_err_clear_on_accept", err_m, 0);
    if (!hold) start = 1'b0;
    while (done_m !== 1'b1 && n < exp_lat + 40) begin
      @(negedge clk);
      n++;
      if (done_m !== 1'b1 && busy_m !== 1'b1) gap++;
    end
    check("latency", n, exp_lat);
    check("busy_held", gap, 0);
    check("busy_low_at_done", busy_m, 0);
    check("ack_err", err_m, exp_err);
    check("frame_len", ev_q.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= ev_q.size() || ev_q[i] != exp_q[i]) mism++;
    check("frame_events", mism, 0);
    if (ev_q.size() >= 9) begin
      for (int i = 0; i < 8; i++) byte_v[7-i] = (ev_q[1+i] == 1);
      check("addr_byte", byte_v, {a, 1'b0});
    end
    if (aa && ev_q.size() >= 18) begin
      for (int i = 0; i < 8; i++) byte_v[7-i] = (ev_q[10+i] == 1);
      check("data_byte", byte_v, d);
    end
    check("scl_period", bad_period, 0);

    @(negedge clk);
    check("done_pulse_width", done_m, 0);
    check("done_count", done_cnt - dstart, 1);
    if (hold) begin
      check("reaccept_after_done", busy_m, 1);
      check("ack_err_cleared_reaccept", err_m, 0);
      start = 1'b0;
      n = 0;
      while (done_m !== 1'b1 && n < exp_lat + 40) begin
        @(negedge clk);
        n++;
      end
      check("second_latency", n, exp_lat - 1);
      @(negedge clk);
    end else begin
      check("idle_after_done", busy_m, 0);
      check("ack_err_held", err_m, exp_err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dstart;
    reset_n = 1'b0;
    start = 1'b0;
    sel = 1'b0;
    addr = 7'd0;
    data_in = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_scl", scl0, 1);
    check("reset_sda_oe", oe0, 0);
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_ack_err", err0, 0);
    check("reset_scl_div1", scl1, 1);
    check("reset_sda_oe_div1", oe1, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of the address byte (CLK_DIV=2)
    sel = 1'b0;
    ack_a_cfg = 1'b1;
    addr = 7'h2A;
    data_in = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (34) @(negedge clk);
    check("busy_mid_addr", busy_m, 1);
    check("scl_low_mid_addr", scl_m, 0);
    check("sda_driven_mid_addr", oe_m, 1);
    dstart = done_cnt;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_scl", scl0, 1);
    check("async_reset_sda_oe", oe0, 0);
    check("async_reset_busy", busy0, 0);
    check("async_reset_done", done0, 0);
    repeat (3) @(negedge clk);
    check("no_done_on_reset", done_cnt - dstart, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed transfers
    run_xfer(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 1'b0);
    run_xfer(1'b0, 7'h50, 8'hA5, 1'b0, 1'b1, 1'b0);
    run_xfer(1'b0, 7'h50, 8'hA5, 1'b1, 1'b0, 1'b0);
    run_xfer(1'b0, 7'h33, 8'h5A, 1'b1, 1'b1, 1'b1);
    run_xfer(1'b1, 7'h7F, 8'h00, 1'b1, 1'b1, 1'b0);

    // Randomised transfers on either divider
    for (int k = 0; k < 6; k++) begin
      run_xfer(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom),
               ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
